// File: rtl/wtf_pkg.sv
// Shared types for the cipher-to-tx byte path.
//   BLOCK_BYTES : bytes per encrypted block
//   BYTE_W      : bits per byte
//   block_t     : one encrypted block, byte k = block[k]
//   ser_state_t : serializer FSM states
package wtf_pkg;

  localparam int BLOCK_BYTES = 16;
  localparam int BYTE_W      = 8;

  typedef logic [BLOCK_BYTES-1:0][BYTE_W-1:0] block_t;

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } ser_state_t;

endpackage

// File: rtl/block_fifo.sv
// Block FIFO: DEPTH entries of W bits, synchronous, show-ahead head.
//   clk_i, rst_ni : clock, synchronous active-low reset
//   push_i/data_i : write data_i at the tail
//   pop_i         : remove the head (ignored when empty)
//   head_o        : current head entry (valid while !empty_o)
//   full_o/empty_o: occupancy flags
//   count_o       : entries held
//   drop_o        : push refused this cycle (full and no pop)
module block_fifo #(
  parameter int DEPTH = 2,
  parameter int W     = 128
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     push_i,
  input  logic [W-1:0]             data_i,
  input  logic                     pop_i,
  output logic [W-1:0]             head_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   count_o,
  output logic                     drop_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  logic [W-1:0]     mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q;
  logic [PTR_W-1:0] rd_ptr_q;
  logic [CNT_W-1:0] count_q;
  logic             pop_eff;
  logic             push_eff;

  assign full_o  = (count_q == FULL_CNT);
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign head_o  = mem_q[rd_ptr_q];

  // A pop in the same cycle frees a slot, so a push into a full FIFO
  // is still accepted then.
  assign pop_eff  = pop_i & ~empty_o;
  assign push_eff = push_i & (~full_o | pop_eff);
  assign drop_o   = push_i & ~push_eff;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_eff) begin
        mem_q[wr_ptr_q] <= data_i;
        wr_ptr_q        <= wr_ptr_q + 1'b1;
      end
      if (pop_eff) begin
        rd_ptr_q <= rd_ptr_q + 1'b1;
      end
      case ({push_eff, pop_eff})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/block_serializer.sv
// Block serializer: queues encrypted blocks and sends them one byte per
// pacing tick to the tx transmitter, byte 0 first.
//   clk_in, rst_in   : clock, synchronous active-low reset
//   block_valid_in   : block_in carries a new block (single cycle)
//   tick_in          : byte pacing strobe
//   enable_in        : low = bytes consumed on tick but not sent
//   tx_busy_in       : high = tick skipped, byte retained
//   byte_valid_out   : single-cycle byte strobe
//   byte_out/byte_index_out/frame_start_out : byte, its index, index==0
//   fill_out         : blocks queued (excludes block being sent)
//   busy_out         : FSM not idle
//   overflow_out     : sticky, a block was dropped on a full FIFO
//
// state | meaning
// IDLE  | waiting for a queued block; loads head into hold and pops
// SEND  | sending hold one byte per usable tick, back to IDLE after last
module block_serializer #(
  parameter int DEPTH           = 2,
  parameter int BYTES_PER_BLOCK = 16,
  parameter int BYTE_W          = 8
) (
  input  logic                                        clk_in,
  input  logic                                        rst_in,
  input  logic                                        block_valid_in,
  input  logic [BYTES_PER_BLOCK-1:0][BYTE_W-1:0]      block_in,
  input  logic                                        tick_in,
  input  logic                                        enable_in,
  input  logic                                        tx_busy_in,
  output logic                                        byte_valid_out,
  output logic [BYTE_W-1:0]                           byte_out,
  output logic [$clog2(BYTES_PER_BLOCK)-1:0]          byte_index_out,
  output logic                                        frame_start_out,
  output logic [$clog2(DEPTH):0]                      fill_out,
  output logic                                        busy_out,
  output logic                                        overflow_out
);

  import wtf_pkg::*;

  localparam int IDX_W   = $clog2(BYTES_PER_BLOCK);
  localparam int BLK_W   = BYTES_PER_BLOCK * BYTE_W;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(BYTES_PER_BLOCK - 1);

  ser_state_t                               state_q;
  logic [BYTES_PER_BLOCK-1:0][BYTE_W-1:0]   hold_q;
  logic [IDX_W-1:0]                         idx_q;
  logic [IDX_W-1:0]                         idx_d;
  logic                                     byte_valid_q;
  logic [BYTE_W-1:0]                        byte_q;
  logic [IDX_W-1:0]                         byte_idx_q;
  logic                                     frame_q;
  logic                                     overflow_q;

  logic             fifo_pop;
  logic [BLK_W-1:0] fifo_head;
  logic             fifo_full;
  logic             fifo_empty;
  logic             fifo_drop;

  assign fifo_pop = (state_q == IDLE) && !fifo_empty;
  assign idx_d    = idx_q + 1'b1;

  block_fifo #(
    .DEPTH (DEPTH),
    .W     (BLK_W)
  ) u_fifo (
    .clk_i   (clk_in),
    .rst_ni  (rst_in),
    .push_i  (block_valid_in),
    .data_i  (block_in),
    .pop_i   (fifo_pop),
    .head_o  (fifo_head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fill_out),
    .drop_o  (fifo_drop)
  );

  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      state_q      <= IDLE;
      hold_q       <= '0;
      idx_q        <= '0;
      byte_valid_q <= 1'b0;
      byte_q       <= '0;
      byte_idx_q   <= '0;
      frame_q      <= 1'b0;
      overflow_q   <= 1'b0;
    end else begin
      byte_valid_q <= 1'b0;
      frame_q      <= 1'b0;
      if (fifo_drop) begin
        overflow_q <= 1'b1;
      end
      case (state_q)
        IDLE: begin
          if (!fifo_empty) begin
            hold_q  <= fifo_head;
            idx_q   <= '0;
            state_q <= SEND;
          end
        end
        SEND: begin
          // A busy tick is skipped entirely; a gated tick still consumes
          // the byte so byte timing stays locked to the audio rate.
          if (tick_in && !tx_busy_in) begin
            if (enable_in) begin
              byte_valid_q <= 1'b1;
              byte_q       <= hold_q[idx_q];
              byte_idx_q   <= idx_q;
              frame_q      <= (idx_q == '0);
            end
            idx_q <= idx_d;
            if (idx_q == LAST_IDX) begin
              state_q <= IDLE;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign byte_valid_out  = byte_valid_q;
  assign byte_out        = byte_q;
  assign byte_index_out  = byte_idx_q;
  assign frame_start_out = frame_q;
  assign busy_out        = (state_q != IDLE);
  assign overflow_out    = overflow_q;

endmodule

// File: tb/tb_block_serializer.sv
module tb_block_serializer;

  logic                  clk_in = 1'b0;
  logic                  rst_in;
  logic                  block_valid_in;
  logic [15:0][7:0]      block_in;
  logic                  tick_in;
  logic                  enable_in;
  logic                  tx_busy_in;
  logic                  byte_valid_out;
  logic [7:0]            byte_out;
  logic [3:0]            byte_index_out;
  logic                  frame_start_out;
  logic [1:0]            fill_out;
  logic                  busy_out;
  logic                  overflow_out;

  int n_vec = 0;
  int n_err = 0;

  // strobe capture
  logic [7:0] q_byte [$];
  logic [3:0] q_idx  [$];
  logic       q_fs   [$];
  int         consec = 0;
  logic       prev_v = 1'b0;

  block_serializer #(
    .DEPTH           (2),
    .BYTES_PER_BLOCK (16),
    .BYTE_W          (8)
  ) dut (
    .clk_in          (clk_in),
    .rst_in          (rst_in),
    .block_valid_in  (block_valid_in),
    .block_in        (block_in),
    .tick_in         (tick_in),
    .enable_in       (enable_in),
    .tx_busy_in      (tx_busy_in),
    .byte_valid_out  (byte_valid_out),
    .byte_out        (byte_out),
    .byte_index_out  (byte_index_out),
    .frame_start_out (frame_start_out),
    .fill_out        (fill_out),
    .busy_out        (busy_out),
    .overflow_out    (overflow_out)
  );

  always #5 clk_in = ~clk_in;

  always @(negedge clk_in) begin
    if (byte_valid_out === 1'b1) begin
      q_byte.push_back(byte_out);
      q_idx.push_back(byte_index_out);
      q_fs.push_back(frame_start_out);
      if (prev_v) consec++;
    end
    prev_v = (byte_valid_out === 1'b1);
  end

  function automatic logic [15:0][7:0] mk_block(input logic [7:0] base);
    logic [15:0][7:0] b;
    for (int k = 0; k < 16; k++) b[k] = base + 8'(k);
    return b;
  endfunction

  task automatic step();
    @(posedge clk_in);
    #1;
  endtask

  task automatic clear_q();
    q_byte.delete();
    q_idx.delete();
    q_fs.delete();
  endtask

  task automatic push(input logic [7:0] base);
    block_valid_in = 1'b1;
    block_in       = mk_block(base);
    step();
    block_valid_in = 1'b0;
  endtask

  task automatic send_tick();
    tick_in = 1'b1;
    step();
    tick_in = 1'b0;
    repeat (5) step();
  endtask

  task automatic do_reset();
    rst_in = 1'b0;
    repeat (3) step();
    rst_in = 1'b1;
    step();
  endtask

  task automatic test_reset();
    do_reset();
    n_vec++; if (byte_valid_out !== 1'b0) begin n_err++; $display("FAIL reset_valid got=%0b exp=0", byte_valid_out); end
    n_vec++; if (byte_out !== 8'h00) begin n_err++; $display("FAIL reset_byte got=%h exp=00", byte_out); end
    n_vec++; if (byte_index_out !== 4'd0) begin n_err++; $display("FAIL reset_idx got=%0d exp=0", byte_index_out); end
    n_vec++; if (frame_start_out !== 1'b0) begin n_err++; $display("FAIL reset_fs got=%0b exp=0", frame_start_out); end
    n_vec++; if (fill_out !== 2'd0) begin n_err++; $display("FAIL reset_fill got=%0d exp=0", fill_out); end
    n_vec++; if (busy_out !== 1'b0) begin n_err++; $display("FAIL reset_busy got=%0b exp=0", busy_out); end
    n_vec++; if (overflow_out !== 1'b0) begin n_err++; $display("FAIL reset_ovf got=%0b exp=0", overflow_out); end
  endtask

  task automatic test_single();
    clear_q();
    push(8'h00);
    n_vec++; if (busy_out !== 1'b0) begin n_err++; $display("FAIL single_busy_t1 got=%0b exp=0", busy_out); end
    n_vec++; if (fill_out !== 2'd1) begin n_err++; $display("FAIL single_fill_t1 got=%0d exp=1", fill_out); end
    step();
    n_vec++; if (busy_out !== 1'b1) begin n_err++; $display("FAIL single_busy_t2 got=%0b exp=1", busy_out); end
    n_vec++; if (fill_out !== 2'd0) begin n_err++; $display("FAIL single_fill_t2 got=%0d exp=0", fill_out); end
    for (int t = 0; t < 16; t++) begin
      send_tick();
      n_vec++; if (busy_out !== (t < 15)) begin n_err++; $display("FAIL single_busy_tick%0d got=%0b exp=%0b", t, busy_out, (t < 15)); end
    end
    n_vec++; if (q_byte.size() != 16) begin n_err++; $display("FAIL single_count got=%0d exp=16", q_byte.size()); end
    for (int k = 0; k < q_byte.size() && k < 16; k++) begin
      n_vec++;
      if (q_byte[k] !== 8'(k) || q_idx[k] !== 4'(k) || q_fs[k] !== (k == 0)) begin
        n_err++;
        $display("FAIL single_byte%0d got=%h/%0d/%0b exp=%h/%0d/%0b", k, q_byte[k], q_idx[k], q_fs[k], 8'(k), k, (k == 0));
      end
    end
    n_vec++; if (fill_out !== 2'd0) begin n_err++; $display("FAIL single_fill_end got=%0d exp=0", fill_out); end
  endtask

  task automatic test_busy_stall();
    clear_q();
    push(8'h10);
    step();
    for (int t = 0; t < 5; t++) send_tick();
    tx_busy_in = 1'b1;
    send_tick();
    tx_busy_in = 1'b0;
    n_vec++; if (q_byte.size() != 5) begin n_err++; $display("FAIL stall_no_strobe got=%0d exp=5", q_byte.size()); end
    n_vec++; if (busy_out !== 1'b1) begin n_err++; $display("FAIL stall_busy got=%0b exp=1", busy_out); end
    send_tick();
    n_vec++; if (q_byte.size() != 6 || q_byte[5] !== 8'h15 || q_idx[5] !== 4'd5) begin
      n_err++; $display("FAIL stall_byte5 got_n=%0d exp byte=15 idx=5", q_byte.size());
    end
    for (int t = 6; t < 16; t++) send_tick();
    n_vec++; if (q_byte.size() != 16) begin n_err++; $display("FAIL stall_count got=%0d exp=16", q_byte.size()); end
    for (int k = 0; k < q_byte.size() && k < 16; k++) begin
      n_vec++;
      if (q_byte[k] !== 8'h10 + 8'(k) || q_idx[k] !== 4'(k)) begin
        n_err++; $display("FAIL stall_byte%0d got=%h/%0d exp=%h/%0d", k, q_byte[k], q_idx[k], 8'h10 + 8'(k), k);
      end
    end
    n_vec++; if (busy_out !== 1'b0) begin n_err++; $display("FAIL stall_busy_end got=%0b exp=0", busy_out); end
  endtask

  task automatic test_gate();
    clear_q();
    push(8'h20);
    step();
    enable_in = 1'b0;
    for (int t = 0; t < 8; t++) send_tick();
    n_vec++; if (q_byte.size() != 0) begin n_err++; $display("FAIL gate_off_count got=%0d exp=0", q_byte.size()); end
    enable_in = 1'b1;
    for (int t = 8; t < 16; t++) send_tick();
    n_vec++; if (q_byte.size() != 8) begin n_err++; $display("FAIL gate_count got=%0d exp=8", q_byte.size()); end
    for (int k = 0; k < q_byte.size() && k < 8; k++) begin
      n_vec++;
      if (q_byte[k] !== 8'h28 + 8'(k) || q_idx[k] !== 4'(k + 8) || q_fs[k] !== 1'b0) begin
        n_err++; $display("FAIL gate_byte%0d got=%h/%0d/%0b exp=%h/%0d/0", k, q_byte[k], q_idx[k], q_fs[k], 8'h28 + 8'(k), k + 8);
      end
    end
    n_vec++; if (busy_out !== 1'b0) begin n_err++; $display("FAIL gate_busy_end got=%0b exp=0", busy_out); end
  endtask

  task automatic test_overflow();
    clear_q();
    push(8'h30);
    step();
    send_tick();
    send_tick();
    push(8'h40);
    push(8'h50);
    n_vec++; if (fill_out !== 2'd2) begin n_err++; $display("FAIL ovf_fill2 got=%0d exp=2", fill_out); end
    n_vec++; if (overflow_out !== 1'b0) begin n_err++; $display("FAIL ovf_early got=%0b exp=0", overflow_out); end
    push(8'h60);
    n_vec++; if (overflow_out !== 1'b1) begin n_err++; $display("FAIL ovf_set got=%0b exp=1", overflow_out); end
    n_vec++; if (fill_out !== 2'd2) begin n_err++; $display("FAIL ovf_fill_hold got=%0d exp=2", fill_out); end
    for (int t = 2; t < 16; t++) send_tick();
    n_vec++; if (fill_out !== 2'd1) begin n_err++; $display("FAIL ovf_fill_after_p got=%0d exp=1", fill_out); end
    for (int t = 0; t < 32; t++) send_tick();
    n_vec++; if (q_byte.size() != 48) begin n_err++; $display("FAIL ovf_count got=%0d exp=48", q_byte.size()); end
    for (int k = 0; k < q_byte.size() && k < 48; k++) begin
      logic [7:0] exp_b;
      exp_b = (k < 16) ? 8'h30 + 8'(k) : (k < 32) ? 8'h40 + 8'(k - 16) : 8'h50 + 8'(k - 32);
      n_vec++;
      if (q_byte[k] !== exp_b || q_idx[k] !== 4'(k % 16)) begin
        n_err++; $display("FAIL ovf_byte%0d got=%h/%0d exp=%h/%0d", k, q_byte[k], q_idx[k], exp_b, k % 16);
      end
    end
    n_vec++; if (overflow_out !== 1'b1) begin n_err++; $display("FAIL ovf_sticky got=%0b exp=1", overflow_out); end
    n_vec++; if (busy_out !== 1'b0 || fill_out !== 2'd0) begin n_err++; $display("FAIL ovf_end got busy=%0b fill=%0d exp 0/0", busy_out, fill_out); end
  endtask

  task automatic test_full_push_pop();
    do_reset();
    clear_q();
    push(8'h60);
    step();
    push(8'h70);
    push(8'h80);
    n_vec++; if (fill_out !== 2'd2) begin n_err++; $display("FAIL fpp_fill_pre got=%0d exp=2", fill_out); end
    for (int t = 0; t < 15; t++) send_tick();
    // last tick moves the FSM to IDLE; the push lands on the IDLE pop cycle
    tick_in = 1'b1;
    step();
    tick_in = 1'b0;
    block_valid_in = 1'b1;
    block_in       = mk_block(8'h90);
    step();
    block_valid_in = 1'b0;
    n_vec++; if (overflow_out !== 1'b0) begin n_err++; $display("FAIL fpp_ovf got=%0b exp=0", overflow_out); end
    n_vec++; if (fill_out !== 2'd2) begin n_err++; $display("FAIL fpp_fill got=%0d exp=2", fill_out); end
    n_vec++; if (busy_out !== 1'b1) begin n_err++; $display("FAIL fpp_busy got=%0b exp=1", busy_out); end
    repeat (4) step();
    for (int t = 0; t < 48; t++) send_tick();
    n_vec++; if (q_byte.size() != 64) begin n_err++; $display("FAIL fpp_count got=%0d exp=64", q_byte.size()); end
    for (int k = 0; k < q_byte.size() && k < 64; k++) begin
      logic [7:0] exp_b;
      exp_b = 8'h60 + 8'h10 * 8'(k / 16) + 8'(k % 16);
      n_vec++;
      if (q_byte[k] !== exp_b) begin
        n_err++; $display("FAIL fpp_byte%0d got=%h exp=%h", k, q_byte[k], exp_b);
      end
    end
    n_vec++; if (fill_out !== 2'd0 || overflow_out !== 1'b0) begin n_err++; $display("FAIL fpp_end got fill=%0d ovf=%0b exp 0/0", fill_out, overflow_out); end
  endtask

  task automatic test_reset_mid();
    clear_q();
    push(8'hA0);
    step();
    push(8'hB0);
    for (int t = 0; t < 8; t++) send_tick();
    n_vec++; if (q_byte.size() != 8 || byte_out !== 8'hA7) begin n_err++; $display("FAIL rmid_pre got_n=%0d byte=%h exp 8/a7", q_byte.size(), byte_out); end
    // also make the FIFO drop one so overflow is set before reset
    push(8'hC0);
    push(8'hD0);
    n_vec++; if (overflow_out !== 1'b1) begin n_err++; $display("FAIL rmid_ovf_pre got=%0b exp=1", overflow_out); end
    rst_in  = 1'b0;
    tick_in = 1'b1;
    step();
    tick_in = 1'b0;
    n_vec++; if (byte_valid_out !== 1'b0) begin n_err++; $display("FAIL rmid_valid got=%0b exp=0", byte_valid_out); end
    n_vec++; if (byte_out !== 8'h00 || byte_index_out !== 4'd0) begin n_err++; $display("FAIL rmid_byte got=%h/%0d exp=00/0", byte_out, byte_index_out); end
    n_vec++; if (fill_out !== 2'd0) begin n_err++; $display("FAIL rmid_fill got=%0d exp=0", fill_out); end
    n_vec++; if (overflow_out !== 1'b0) begin n_err++; $display("FAIL rmid_ovf got=%0b exp=0", overflow_out); end
    n_vec++; if (busy_out !== 1'b0 || frame_start_out !== 1'b0) begin n_err++; $display("FAIL rmid_busy got busy=%0b fs=%0b exp 0/0", busy_out, frame_start_out); end
    rst_in = 1'b1;
    step();
    clear_q();
    for (int t = 0; t < 20; t++) send_tick();
    n_vec++; if (q_byte.size() != 0) begin n_err++; $display("FAIL rmid_quiet got=%0d exp=0", q_byte.size()); end
    push(8'hE0);
    step();
    send_tick();
    n_vec++; if (q_byte.size() != 1 || q_byte[0] !== 8'hE0 || q_fs[0] !== 1'b1) begin
      n_err++; $display("FAIL rmid_new got_n=%0d exp 1 strobe byte=e0 fs=1", q_byte.size());
    end
  endtask

  initial begin
    rst_in         = 1'b0;
    block_valid_in = 1'b0;
    block_in       = '0;
    tick_in        = 1'b0;
    enable_in      = 1'b1;
    tx_busy_in     = 1'b0;
    test_reset();
    test_single();
    test_busy_stall();
    test_gate();
    test_overflow();
    test_full_push_pop();
    test_reset_mid();
    n_vec++; if (consec != 0) begin n_err++; $display("FAIL consecutive_strobes got=%0d exp=0", consec); end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
